// File: rtl/imem_loadable_rom.sv
// Purpose : synchronous instruction ROM whose image can be rewritten at run time through a streaming load port.
// Latency : fetch result is registered, visible one cycle after fetch_addr; load words are written the cycle they are accepted.
// Backpr. : stall holds instr/instr_valid/fetch_err; load_ready is high only in LOAD, and fetch is blocked while loading.
//
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   fetch_addr, stall          - byte address from the PC, pipeline stall
//   instr, instr_valid, fetch_err - registered fetch result
//   load_start                 - one-cycle request to start loading at word 0 (honoured in RUN only)
//   load_valid/load_last/load_data, load_ready - streaming load handshake
//   load_busy, load_done, load_count - load status (CPU must be held while busy)
module imem_loadable_rom #(
  parameter int                ADDR_BITS    = 8,
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = 32'h0800_0000,
  parameter bit                WRAP         = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          fetch_addr,
  input  logic                 stall,
  output logic [DATA_W-1:0]    instr,
  output logic                 instr_valid,
  output logic                 fetch_err,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic                 load_last,
  input  logic [DATA_W-1:0]    load_data,
  output logic                 load_ready,
  output logic                 load_busy,
  output logic                 load_done,
  output logic [ADDR_BITS:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_BITS-1:0]   ptr_q;
  logic [ADDR_BITS:0]     count_q;
  // One flop per word: a word reads back DEFAULT_WORD until it has been loaded
  // at least once since reset. This is what lets the array itself stay unreset.
  logic [DEPTH-1:0]       written_q;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic [ADDR_BITS-1:0]   fetch_idx;
  logic                   misaligned;
  logic                   out_of_range;
  logic                   fetch_bad;
  logic [DATA_W-1:0]      fetch_word;
  logic                   load_accept;
  logic                   load_final;

  assign fetch_idx    = fetch_addr[ADDR_BITS+1:2];
  assign misaligned   = |fetch_addr[1:0];
  // With WRAP set the upper address bits alias onto the array instead of faulting.
  assign out_of_range = !WRAP && (|(fetch_addr >> (ADDR_BITS + 2)));
  assign fetch_bad    = misaligned | out_of_range;
  assign fetch_word   = (!fetch_bad && written_q[fetch_idx]) ? mem[fetch_idx] : DEFAULT_WORD;

  assign load_accept  = load_valid & load_ready;
  // The last array slot ends the load even without load_last, so the pointer never wraps mid-image.
  assign load_final   = load_accept & (load_last | (ptr_q == ADDR_BITS'(DEPTH - 1)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (load_start) state_d = LOAD;
      LOAD:    if (load_final) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    load_busy  = 1'b0;
    load_ready = 1'b0;
    load_done  = 1'b0;
    unique case (state_q)
      LOAD: begin
        load_busy  = 1'b1;
        load_ready = 1'b1;
      end
      DONE:    load_done = 1'b1;
      default: ;
    endcase
  end

  assign load_count = count_q;

  // Fetch pipeline register. Outside RUN the output is forced invalid, so the
  // fetch registered during the load_start cycle still completes, and the first
  // fetch after DONE shows up one cycle into RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= DEFAULT_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (state_q != RUN) begin
      instr       <= DEFAULT_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (!stall) begin
      instr       <= fetch_word;
      instr_valid <= 1'b1;
      fetch_err   <= fetch_bad;
    end
  end

  // Load pointer, word count and written bitmap
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      count_q   <= '0;
      written_q <= '0;
    end else if (state_q == RUN && load_start) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (load_accept) begin
      ptr_q            <= ptr_q + 1'b1;
      count_q          <= count_q + 1'b1;
      written_q[ptr_q] <= 1'b1;
    end
  end

  // Instruction array: write-only here, read through fetch_word. LOAD and RUN
  // are exclusive, so a read and a write never land in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && load_accept) begin
      mem[ptr_q] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_loadable_rom.sv
module tb_imem_loadable_rom;

  localparam logic [31:0] DEF = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic        stall = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = '0;

  logic [31:0] instr, instr_nw;
  logic        instr_valid, instr_valid_nw;
  logic        fetch_err, fetch_err_nw;
  logic        load_ready, load_ready_nw;
  logic        load_busy, load_busy_nw;
  logic        load_done, load_done_nw;
  logic [8:0]  load_count, load_count_nw;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_loadable_rom #(.ADDR_BITS(8), .DATA_W(32), .DEFAULT_WORD(DEF), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .fetch_err(fetch_err),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_data(load_data), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .load_count(load_count)
  );

  imem_loadable_rom #(.ADDR_BITS(8), .DATA_W(32), .DEFAULT_WORD(DEF), .WRAP(1'b0)) dut_nw (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .stall(stall),
    .instr(instr_nw), .instr_valid(instr_valid_nw), .fetch_err(fetch_err_nw),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_data(load_data), .load_ready(load_ready_nw), .load_busy(load_busy_nw),
    .load_done(load_done_nw), .load_count(load_count_nw)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] addr);
    fetch_addr = addr;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_instr", instr, DEF);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    check("rst_ready", {31'b0, load_ready}, 32'd0);
    check("rst_busy", {31'b0, load_busy}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_count", {23'b0, load_count}, 32'd0);
    reset = 1'b0;

    // Empty image reads back DEFAULT_WORD
    fetch(32'h0);
    check("empty0_instr", instr, DEF);
    check("empty0_valid", {31'b0, instr_valid}, 32'd1);
    check("empty0_err", {31'b0, fetch_err}, 32'd0);
    fetch(32'h4);
    check("empty4_instr", instr, DEF);
    check("empty4_valid", {31'b0, instr_valid}, 32'd1);
    fetch(32'h3FC);
    check("empty3fc_instr", instr, DEF);
    check("empty3fc_err", {31'b0, fetch_err}, 32'd0);
    check("empty3fc_err_nw", {31'b0, fetch_err_nw}, 32'd0);

    // Three-word load with load_last
    load_start = 1'b1;
    fetch_addr = 32'h0;
    tick();
    load_start = 1'b0;
    check("ld3_busy", {31'b0, load_busy}, 32'd1);
    check("ld3_ready", {31'b0, load_ready}, 32'd1);
    check("ld3_startfetch_valid", {31'b0, instr_valid}, 32'd1);
    load_valid = 1'b1;
    load_data = 32'h3c104000;
    tick();
    check("ld3_valid_blocked", {31'b0, instr_valid}, 32'd0);
    check("ld3_count1", {23'b0, load_count}, 32'd1);
    load_data = 32'h22100018;
    tick();
    load_data = 32'h00008020;
    load_last = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
    check("ld3_done", {31'b0, load_done}, 32'd1);
    check("ld3_count", {23'b0, load_count}, 32'd3);
    check("ld3_busy_done", {31'b0, load_busy}, 32'd0);
    check("ld3_ready_done", {31'b0, load_ready}, 32'd0);
    tick();
    check("ld3_done_pulse", {31'b0, load_done}, 32'd0);
    check("ld3_count_hold", {23'b0, load_count}, 32'd3);
    check("ld3_run_valid", {31'b0, instr_valid}, 32'd0);

    fetch(32'h4);
    check("rd4_instr", instr, 32'h22100018);
    check("rd4_valid", {31'b0, instr_valid}, 32'd1);
    fetch(32'hC);
    check("rdC_instr", instr, DEF);

    // Stall holds the 0x8 result while the address moves
    fetch(32'h8);
    check("rd8_instr", instr, 32'h00008020);
    stall = 1'b1;
    fetch(32'h0);
    check("stall1_instr", instr, 32'h00008020);
    fetch(32'h4);
    check("stall2_instr", instr, 32'h00008020);
    check("stall2_valid", {31'b0, instr_valid}, 32'd1);
    fetch(32'hC);
    check("stall3_instr", instr, 32'h00008020);
    stall = 1'b0;
    fetch(32'h0);
    check("unstall_instr", instr, 32'h3c104000);

    // Misaligned and out-of-range fetches
    fetch(32'h6);
    check("mis_err", {31'b0, fetch_err}, 32'd1);
    check("mis_instr", instr, DEF);
    check("mis_valid", {31'b0, instr_valid}, 32'd1);
    fetch(32'h400);
    check("oor_err_nw", {31'b0, fetch_err_nw}, 32'd1);
    check("oor_instr_nw", instr_nw, DEF);
    check("wrap400_err", {31'b0, fetch_err}, 32'd0);
    check("wrap400_instr", instr, 32'h3c104000);
    fetch(32'h404);
    check("wrap404_instr", instr, 32'h22100018);
    check("wrap404_err", {31'b0, fetch_err}, 32'd0);
    fetch(32'h8);
    check("aligned_err_clear", {31'b0, fetch_err}, 32'd0);

    // Full 256-word load without load_last; mid-load load_start is ignored
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      load_data = 32'hA000_0000 + i;
      load_start = (i == 100);
      tick();
    end
    load_start = 1'b0;
    check("full_count255", {23'b0, load_count}, 32'd255);
    check("full_busy255", {31'b0, load_busy}, 32'd1);
    check("full_done255", {31'b0, load_done}, 32'd0);
    load_data = 32'hA000_00FF;
    tick();
    load_valid = 1'b0;
    check("full_done", {31'b0, load_done}, 32'd1);
    check("full_count", {23'b0, load_count}, 32'd256);
    tick();
    fetch(32'h3FC);
    check("full_rd3fc", instr, 32'hA000_00FF);
    fetch(32'h190);
    check("full_rd190", instr, 32'hA000_0064);
    fetch(32'h0);
    check("full_rd0", instr, 32'hA000_0000);

    // Reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 32'h1111_1111;
    tick();
    load_data = 32'h2222_2222;
    tick();
    load_valid = 1'b0;
    check("mid_busy_before", {31'b0, load_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy_after", {31'b0, load_busy}, 32'd0);
    check("mid_count_after", {23'b0, load_count}, 32'd0);
    fetch(32'h0);
    check("mid_rd0", instr, DEF);
    check("mid_rd0_valid", {31'b0, instr_valid}, 32'd1);
    fetch(32'h3FC);
    check("mid_rd3fc", instr, DEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loadable_rom.md
Name: imem_loadable_rom

Overview:
- Parametrised, synchronous successor to the combinational instruction ROM of the MIPS32 pipeline.
- Serves word-aligned instruction fetches with 1-cycle registered latency and stall-hold.
- Has a streaming program-load port, so a boot loader or UART bridge can rewrite the image at run time.
- Unwritten words read back DEFAULT_WORD; fetch is blocked while a load is in progress.

Parameters:
- ADDR_BITS, 8, word-index width; DEPTH = 2**ADDR_BITS words
- DATA_W, 32, instruction width
- DEFAULT_WORD, 32'h0800_0000, value returned for unwritten, misaligned or out-of-range words (jump to 0)
- WRAP, 1, 1 = ignore fetch_addr bits above ADDR_BITS+1 (aliasing); 0 = those addresses are out of range

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_addr  in  32  byte address from PC; word index = fetch_addr[ADDR_BITS+1:2]
- stall  in  1  pipeline stall; holds instr/instr_valid/fetch_err
- instr  out  DATA_W  registered instruction
- instr_valid  out  1  instr is usable this cycle
- fetch_err  out  1  registered flag: last fetch was misaligned or out of range
- load_start  in  1  single-cycle request to begin loading at word 0
- load_valid  in  1  load_data is presented
- load_last  in  1  qualifies the final load word
- load_data  in  DATA_W  word to write
- load_ready  out  1  block accepts load_data this cycle
- load_busy  out  1  load in progress; the CPU must be held
- load_done  out  1  one-cycle pulse after the final word is written
- load_count  out  ADDR_BITS+1  words written in the current/last load

Behaviour:
- Reset values:
  - instr = DEFAULT_WORD; instr_valid = 0; fetch_err = 0
  - load_ready = 0; load_busy = 0; load_done = 0; load_count = 0
  - state = RUN; write pointer = 0
  - per-word written bitmap cleared to all zero
  - memory array contents are not reset, but are masked by the bitmap
- States: RUN, LOAD, DONE.
- RUN:
  - While stall = 0, each cycle registers instr, instr_valid = 1 and fetch_err, computed from fetch_addr. The result is visible the next cycle.
  - While stall = 1, instr, instr_valid and fetch_err hold their values.
  - Word value = mem[idx] if bitmap[idx] = 1, else DEFAULT_WORD.
  - Misaligned (fetch_addr[1:0] != 0): instr = DEFAULT_WORD, fetch_err = 1.
  - WRAP = 0 and any of fetch_addr[31:ADDR_BITS+2] != 0: instr = DEFAULT_WORD, fetch_err = 1.
  - WRAP = 1: upper bits ignored, no error.
  - load_start = 1 -> LOAD next cycle; pointer = 0; load_count = 0. The fetch presented in that same cycle still completes normally.
- LOAD:
  - load_busy = 1; load_ready = 1; instr_valid = 0; instr = DEFAULT_WORD; stall has no effect.
  - On load_valid & load_ready: mem[ptr] = load_data, bitmap[ptr] = 1, ptr++, load_count++.
  - The accepted word is the final word when load_last = 1 or ptr = DEPTH-1. The next cycle is DONE.
  - Words beyond the loaded length keep their previous bitmap/contents. The load overwrites only; it does not clear.
  - load_start during LOAD is ignored.
- DONE:
  - Lasts exactly one cycle: load_done = 1, load_busy = 0, load_ready = 0.
  - Then RUN, where the first fetch yields instr_valid one cycle later.
- load_start in DONE is ignored. load_count holds until the next load_start.
- Reset mid-load: return to RUN and clear the bitmap. The image reads back as all DEFAULT_WORD.
- Writes and reads never occur in the same cycle, because LOAD blocks fetch, so there is no read-during-write hazard.
- Memory is inferred as a single-port synchronous array. The bitmap is DEPTH flops.

Test Plan:
- Reset, then fetch 0x00, 0x04, 0x3FC -> each instr = 32'h0800_0000, instr_valid = 1 one cycle after its address, fetch_err = 0.
- Start a load and stream 32'h3c104000, 32'h22100018, 32'h00008020 with load_last on the third word -> load_done pulses one cycle after the third acceptance, load_count = 3. Then fetch 0x4 -> 32'h22100018; fetch 0xC -> 32'h0800_0000.
- Fetch 0x8, then assert stall for 3 cycles while fetch_addr changes -> instr holds the 0x8 word for all 3 cycles; the new address is taken on the first unstalled cycle.
- Fetch 0x6 -> fetch_err = 1, instr = DEFAULT_WORD. With WRAP = 0, fetch 0x400 -> fetch_err = 1. With WRAP = 1, 0x404 returns the word at 0x4.
- Load 256 words with load_last never asserted -> auto-terminates after word 255, load_count = 256, load_done = 1. A load_start pulse mid-load causes no restart.
- Assert reset after 2 of 5 load words -> load_busy = 0 the next cycle; fetch 0x0 returns DEFAULT_WORD.
